full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//   One-bit full adder cell. It is the carry-chain building block of the 4-bit
//   structural ripple adder (ADD4): four instances, with carry-out of bit i
//   wired to carry-in of bit i+1.
//   The sum/carry path is purely combinational so the ripple settles within one
//   cycle. An optional registered copy of the result and a saturating
//   carry-event counter sit alongside for pipelined users and for debug.
// PARAMETERS
//   CNT_W   8   width of carry_cnt, the saturating carry-out event counter
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   s          out  1       combinational sum, a ^ b ^ ci
//   co         out  1       combinational carry, (a&b) | (a&ci) | (b&ci)
//   a          in   1       addend bit
//   b          in   1       addend bit
//   ci         in   1       carry-in
//   in_valid   in   1       sample request for the registered path
//   s_q        out  1       registered sum
//   co_q       out  1       registered carry
//   out_valid  out  1       s_q/co_q hold a sample taken on the previous cycle
//   carry_cnt  out  CNT_W   number of sampled operations with co=1, saturating
//   Declaration order: s, co, a, b, ci, clk, rst_n, in_valid, s_q, co_q,
//   out_valid, carry_cnt. This keeps the 5-port positional instantiation
//   FA(s,co,a,b,ci) legal. Unconnected trailing inputs leave the registered
//   outputs don't-care; s and co stay correct.
// BEHAVIOUR
//   - s and co: zero latency, no dependence on clk, rst_n or in_valid.
//     X/Z on any input propagates per normal Verilog operator semantics.
//   - {co,s} == a + b + ci, a 2-bit result in the range 0..3.
//   - Reset (rst_n=0, async, takes effect immediately):
//     s_q=0, co_q=0, out_valid=0, carry_cnt=0.
//     Reset asserted mid-operation discards any pending sample.
//   - On each posedge clk with rst_n=1:
//     out_valid <= in_valid.
//     If in_valid=1: s_q <= s and co_q <= co.
//     If in_valid=0: s_q and co_q hold their previous values.
//   - carry_cnt increments when in_valid=1 and co=1.
//     It saturates at 2^CNT_W-1 and never wraps.
//   - Latency of the registered path is 1 cycle. There is no back-pressure:
//     every accepted sample appears on the next cycle.
//   - Back-to-back in_valid on consecutive cycles is supported.
//   - Deassertion of rst_n: the first active edge behaves as a normal cycle.
// STRUCTURE
//   - No shared package is needed. CNT_W is local.
//   - A one-place sum/carry expression can be shared as a function if desired.
//   - No sub-module: one always_ff block for the registers, continuous
//     assigns for s and co.
// TESTING
//   1. Exhaustive combinational check, all 8 {a,b,ci} combinations:
//      {co,s}=a+b+ci. Spot checks: 1,1,1 -> s=1,co=1 and 0,1,0 -> s=1,co=0.
//   2. Reset: rst_n=0 asynchronously between edges ->
//      s_q=0, co_q=0, out_valid=0, carry_cnt=0 immediately.
//      s and co still track the inputs during reset.
//   3. Registered path: in_valid=1 with a=1,b=1,ci=0 ->
//      next edge gives s_q=0, co_q=1, out_valid=1.
//      Then in_valid=0 -> s_q and co_q hold, out_valid=0.
//   4. Saturation: CNT_W=2, drive 5 valid samples with a=b=1 ->
//      carry_cnt sequence 1,2,3,3,3.
//   5. Ripple chain: 4 instances form ADD4 with A=4'b1111, B=4'b0001, ci=1 ->
//      s=4'b0001, co=1 in the same time step.
//      Also apply random A and B for 2000 ns and compare against A+B+ci.
//   6. Reset mid-stream: assert rst_n=0 while in_valid=1 ->
//      no sample is captured and carry_cnt=0 after release.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared sum/carry expression for the one-bit full adder cell.
// Bitwise operators keep X/Z propagation identical to the textbook equations.
package full_adder_pkg;

  function automatic logic [1:0] fa_sum_carry(input logic a, input logic b, input logic ci);
    logic sum;
    logic carry;
    sum   = a ^ b ^ ci;
    carry = (a & b) | (a & ci) | (b & ci);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder with a combinational sum/carry path plus an optional
// registered copy of the result and a saturating carry-event counter.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  output logic             s,
  output logic             co,
  input  logic             a,
  input  logic             b,
  input  logic             ci,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             s_q,
  output logic             co_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Port order keeps the classic positional FA(s, co, a, b, ci) hookup legal.
  assign {co, s} = fa_sum_carry(a, b, ci);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 1'b0;
      co_q      <= 1'b0;
      out_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q  <= s;
        co_q <= co;
        // Saturate rather than wrap so a long debug run never reports a small count.
        if (co && (carry_cnt != CNT_MAX)) begin
          carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: combinational truth table, reset, registered
// path, counter saturation and a four-cell ripple chain.
module tb_full_adder;

  logic clk;
  logic rst_n;

  logic a, b, ci, in_valid;
  logic s, co, s_q, co_q, out_valid;
  logic [7:0] carry_cnt;

  logic sat_a, sat_b, sat_ci, sat_valid;
  logic sat_s, sat_co, sat_s_q, sat_co_q, sat_out_valid;
  logic [1:0] sat_cnt;

  logic [3:0] add_a, add_b, add_s;
  logic       add_ci;
  logic [4:0] chain_c;
  logic [3:0] chain_s_q, chain_co_q, chain_ov;
  logic [7:0] chain_cnt [4];

  int vectors;
  int miscompares;

  full_adder #(.CNT_W(8)) dut (
    .s(s), .co(co), .a(a), .b(b), .ci(ci), .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .s_q(s_q), .co_q(co_q), .out_valid(out_valid),
    .carry_cnt(carry_cnt)
  );

  full_adder #(.CNT_W(2)) dut_sat (
    .s(sat_s), .co(sat_co), .a(sat_a), .b(sat_b), .ci(sat_ci), .clk(clk),
    .rst_n(rst_n), .in_valid(sat_valid), .s_q(sat_s_q), .co_q(sat_co_q),
    .out_valid(sat_out_valid), .carry_cnt(sat_cnt)
  );

  assign chain_c[0] = add_ci;

  for (genvar g = 0; g < 4; g++) begin : g_add4
    full_adder #(.CNT_W(8)) fa (
      .s(add_s[g]), .co(chain_c[g+1]), .a(add_a[g]), .b(add_b[g]),
      .ci(chain_c[g]), .clk(clk), .rst_n(rst_n), .in_valid(1'b0),
      .s_q(chain_s_q[g]), .co_q(chain_co_q[g]), .out_valid(chain_ov[g]),
      .carry_cnt(chain_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = 1'b1; b = 1'b0; ci = 1'b1;
    #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b000 || carry_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_init: s_q/co_q/ov=%b cnt=%0d, want 000 cnt=0", {s_q, co_q, out_valid}, carry_cnt);
    end
    vectors++;
    if ({co, s} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_comb_101: {co,s}=%b want 10", {co, s});
    end
    a = 1'b0;
    #1;
    vectors++;
    if ({co, s} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_comb_001: {co,s}=%b want 01", {co, s});
    end
    // First edge after release must capture normally.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; ci = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b111 || carry_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL first_edge: s_q/co_q/ov=%b cnt=%0d, want 111 cnt=1", {s_q, co_q, out_valid}, carry_cnt);
    end
    // Async assertion between edges clears at once.
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b000 || carry_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: s_q/co_q/ov=%b cnt=%0d, want 000 cnt=0", {s_q, co_q, out_valid}, carry_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb();
    logic [2:0] v;
    logic [1:0] expected;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, ci} = v;
      expected = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
      #1;
      vectors++;
      if ({co, s} !== expected) begin
        miscompares++;
        $display("[TB] FAIL comb_%b: {co,s}=%b want %b", v, {co, s}, expected);
      end
    end
    a = 1'b1; b = 1'b1; ci = 1'b1; #1;
    vectors++;
    if (s !== 1'b1 || co !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL spot_111: s=%b co=%b want s=1 co=1", s, co);
    end
    a = 1'b0; b = 1'b1; ci = 1'b0; #1;
    vectors++;
    if (s !== 1'b1 || co !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL spot_010: s=%b co=%b want s=1 co=0", s, co);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a = 1'b1; b = 1'b1; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b011 || carry_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL reg_capture: s_q/co_q/ov=%b cnt=%0d, want 011 cnt=1", {s_q, co_q, out_valid}, carry_cnt);
    end
    @(negedge clk);
    a = 1'b1; b = 1'b0; ci = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b010 || carry_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL reg_hold: s_q/co_q/ov=%b cnt=%0d, want 010 cnt=1", {s_q, co_q, out_valid}, carry_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] vec [6] = '{3'b001, 3'b110, 3'b111, 3'b000, 3'b011, 3'b100};
    logic [1:0] expected;
    int         exp_cnt;
    exp_cnt = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {a, b, ci} = vec[i];
      in_valid = 1'b1;
      expected = 2'(int'(vec[i][2]) + int'(vec[i][1]) + int'(vec[i][0]));
      if (expected[1]) exp_cnt++;
      @(posedge clk); #1;
      vectors++;
      if ({co_q, s_q} !== expected || out_valid !== 1'b1 || carry_cnt !== 8'(exp_cnt)) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d: {co_q,s_q}=%b ov=%b cnt=%0d, want %b ov=1 cnt=%0d", i, {co_q, s_q}, out_valid, carry_cnt, expected, exp_cnt);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] expected [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sat_a = 1'b1; sat_b = 1'b1; sat_ci = 1'b0; sat_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (sat_cnt !== expected[i]) begin
        miscompares++;
        $display("[TB] FAIL sat_%0d: carry_cnt=%0d want %0d", i, sat_cnt, expected[i]);
      end
    end
    @(negedge clk);
    sat_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    a = 1'b1; b = 1'b1; ci = 1'b1; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b000 || carry_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_hold: s_q/co_q/ov=%b cnt=%0d, want 000 cnt=0", {s_q, co_q, out_valid}, carry_cnt);
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({s_q, co_q, out_valid} !== 3'b000 || carry_cnt !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_release: s_q/co_q/ov=%b cnt=%0d, want 000 cnt=0", {s_q, co_q, out_valid}, carry_cnt);
    end
  endtask

  task automatic test_ripple();
    logic [4:0] expected;
    add_a = 4'b1111; add_b = 4'b0001; add_ci = 1'b1;
    #1;
    vectors++;
    if (add_s !== 4'b0001 || chain_c[4] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add4_directed: s=%b co=%b want s=0001 co=1", add_s, chain_c[4]);
    end
    for (int i = 0; i < 200; i++) begin
      add_a  = 4'($urandom_range(0, 15));
      add_b  = 4'($urandom_range(0, 15));
      add_ci = 1'($urandom_range(0, 1));
      expected = 5'(int'(add_a) + int'(add_b) + int'(add_ci));
      #10;
      vectors++;
      if ({chain_c[4], add_s} !== expected) begin
        miscompares++;
        $display("[TB] FAIL add4_rand: A=%0d B=%0d ci=%b got %0d want %0d", add_a, add_b, add_ci, {chain_c[4], add_s}, expected);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; ci = 1'b0; in_valid = 1'b0;
    sat_a = 1'b0; sat_b = 1'b0; sat_ci = 1'b0; sat_valid = 1'b0;
    add_a = 4'd0; add_b = 4'd0; add_ci = 1'b0;
    test_reset();
    test_comb();
    test_registered();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    test_ripple();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
